// File: rtl/clock_pkg.sv
// Shared types and constants for the BCD clock core.
// Holds mode encodings, BCD digit types and field moduli.
package clock_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [7:0] bcd2_t;

  typedef enum logic [2:0] {
    M_CLOCK       = 3'd0,
    M_SW          = 3'd1,
    M_SET_SEC     = 3'd2,
    M_SET_MIN     = 3'd3,
    M_SET_HOUR    = 3'd4,
    M_SET_AL_MIN  = 3'd5,
    M_SET_AL_HOUR = 3'd6,
    M_RSV         = 3'd7
  } mode_e;

  localparam int MOD_60  = 60;
  localparam int MOD_24  = 24;
  localparam int MOD_100 = 100;

  // Elaboration-time only: largest legal value of a field in BCD.
  function automatic bcd2_t bcd_last(input int m);
    bcd_t hi;
    bcd_t lo;
    hi = 4'((m - 1) / 10);
    lo = 4'((m - 1) % 10);
    return {hi, lo};
  endfunction

  function automatic bcd2_t bcd_next(
    input bcd2_t v,
    input bcd2_t last
  );
    bcd2_t n;
    if (v == last)
      n = '0;
    else if (v[3:0] == 4'd9)
      n = {v[7:4] + 4'd1, 4'd0};
    else
      n = {v[7:4], v[3:0] + 4'd1};
    return n;
  endfunction

endpackage

// File: rtl/clock_if.sv
// Front-panel bundle: mode, buttons, alarm arm in;
// display digits and status strobes out.
interface clock_if;
  logic [2:0]  mode;
  logic        btn_inc;
  logic        btn_aux;
  logic        alarm_en;
  logic [23:0] digits;
  logic        alarm;
  logic        sw_run;
  logic        tick_1hz;

  modport master (
    output mode, btn_inc, btn_aux, alarm_en,
    input  digits, alarm, sw_run, tick_1hz
  );

  modport slave (
    input  mode, btn_inc, btn_aux, alarm_en,
    output digits, alarm, sw_run, tick_1hz
  );
endinterface

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter wrapping at MOD-1 -> 0.
// o_co is high when this increment wraps the counter.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter int MOD = 60
) (
  input  logic  clk,
  input  logic  i_inc,
  input  logic  i_clr,
  output bcd2_t o_q,
  output logic  o_co
);

  localparam bcd2_t LAST = bcd_last(MOD);

  bcd2_t r_q;

  always_ff @(posedge clk) begin
    if (i_clr)
      r_q <= '0;
    else if (i_inc)
      r_q <= bcd_next(r_q, LAST);
  end

  assign o_q  = r_q;
  assign o_co = i_inc && (r_q == LAST);

endmodule

// File: rtl/clock_core.sv
// Time-of-day clock with alarm and stopwatch, all
// counters in BCD, driven from one prescaled clock.
module clock_core
  import clock_pkg::*;
#(
  parameter int CLK_HZ    = 50000000,
  parameter int ALARM_SEC = 60
) (
  input logic   clk,
  input logic   rst,
  clock_if.slave bus
);

  localparam int DIV = CLK_HZ / 100;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [7:0] AL_LAST = 8'(ALARM_SEC - 1);
  localparam bcd2_t L60 = bcd_last(MOD_60);
  localparam bcd2_t L24 = bcd_last(MOD_24);

  logic [PW-1:0] r_pre;
  logic w_tick_100;
  logic w_tick_1hz;
  bcd2_t w_div_q;

  assign w_tick_100 = (r_pre == PRE_LAST);

  always_ff @(posedge clk) begin
    if (rst || w_tick_100)
      r_pre <= '0;
    else
      r_pre <= r_pre + PW'(1);
  end

  bcd_mod_counter #(.MOD(MOD_100)) u_div (
    .clk(clk), .i_inc(w_tick_100), .i_clr(rst),
    .o_q(w_div_q), .o_co(w_tick_1hz)
  );

  logic [1:0] r_inc_s;
  logic [1:0] r_aux_s;
  logic r_inc_d;
  logic r_aux_d;
  logic w_p_inc;
  logic w_p_aux;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inc_s <= '0;
      r_aux_s <= '0;
      r_inc_d <= 1'b0;
      r_aux_d <= 1'b0;
    end else begin
      r_inc_s <= {r_inc_s[0], bus.btn_inc};
      r_aux_s <= {r_aux_s[0], bus.btn_aux};
      r_inc_d <= r_inc_s[1];
      r_aux_d <= r_aux_s[1];
    end
  end

  assign w_p_inc = r_inc_s[1] & ~r_inc_d;
  assign w_p_aux = r_aux_s[1] & ~r_aux_d;

  logic w_m_sw, w_m_ss, w_m_sm;
  logic w_m_sh, w_m_am, w_m_ah;

  always_comb begin
    w_m_sw = 1'b0;
    w_m_ss = 1'b0;
    w_m_sm = 1'b0;
    w_m_sh = 1'b0;
    w_m_am = 1'b0;
    w_m_ah = 1'b0;
    case (mode_e'(bus.mode))
      M_SW:          w_m_sw = 1'b1;
      M_SET_SEC:     w_m_ss = 1'b1;
      M_SET_MIN:     w_m_sm = 1'b1;
      M_SET_HOUR:    w_m_sh = 1'b1;
      M_SET_AL_MIN:  w_m_am = 1'b1;
      M_SET_AL_HOUR: w_m_ah = 1'b1;
      default: ;
    endcase
  end

  logic w_adv;
  assign w_adv = w_tick_1hz & ~(w_m_ss | w_m_sm | w_m_sh);

  bcd2_t w_sec, w_min, w_hr;
  logic w_sec_co, w_min_co, w_hr_co;

  bcd_mod_counter #(.MOD(MOD_60)) u_sec (
    .clk(clk), .i_inc(w_adv | (w_m_ss & w_p_inc)),
    .i_clr(rst), .o_q(w_sec), .o_co(w_sec_co)
  );

  bcd_mod_counter #(.MOD(MOD_60)) u_min (
    .clk(clk),
    .i_inc((w_adv & w_sec_co) | (w_m_sm & w_p_inc)),
    .i_clr(rst), .o_q(w_min), .o_co(w_min_co)
  );

  bcd_mod_counter #(.MOD(MOD_24)) u_hr (
    .clk(clk),
    .i_inc((w_adv & w_min_co) | (w_m_sh & w_p_inc)),
    .i_clr(rst), .o_q(w_hr), .o_co(w_hr_co)
  );

  bcd2_t w_al_min, w_al_hr;
  logic w_al_min_co, w_al_hr_co;

  bcd_mod_counter #(.MOD(MOD_60)) u_al_min (
    .clk(clk), .i_inc(w_m_am & w_p_inc),
    .i_clr(rst), .o_q(w_al_min), .o_co(w_al_min_co)
  );

  bcd_mod_counter #(.MOD(MOD_24)) u_al_hr (
    .clk(clk), .i_inc(w_m_ah & w_p_inc),
    .i_clr(rst), .o_q(w_al_hr), .o_co(w_al_hr_co)
  );

  logic r_sw_run;
  logic w_sw_clr;
  bcd2_t w_sw_cc, w_sw_ss, w_sw_mm;
  logic w_cc_co, w_ss_co, w_mm_co;

  assign w_sw_clr = rst | (w_m_sw & w_p_aux);

  always_ff @(posedge clk) begin
    if (w_sw_clr)
      r_sw_run <= 1'b0;
    else if (w_m_sw & w_p_inc)
      r_sw_run <= ~r_sw_run;
  end

  bcd_mod_counter #(.MOD(MOD_100)) u_sw_cc (
    .clk(clk), .i_inc(w_tick_100 & r_sw_run),
    .i_clr(w_sw_clr), .o_q(w_sw_cc), .o_co(w_cc_co)
  );

  bcd_mod_counter #(.MOD(MOD_60)) u_sw_ss (
    .clk(clk), .i_inc(w_cc_co),
    .i_clr(w_sw_clr), .o_q(w_sw_ss), .o_co(w_ss_co)
  );

  bcd_mod_counter #(.MOD(MOD_60)) u_sw_mm (
    .clk(clk), .i_inc(w_ss_co),
    .i_clr(w_sw_clr), .o_q(w_sw_mm), .o_co(w_mm_co)
  );

  // Match on the advance that rolls time onto HH:MM:00.
  bcd2_t w_nxt_min, w_nxt_hr;
  logic w_match, w_any_p;
  logic r_alarm;
  logic [7:0] r_al_cnt;

  assign w_nxt_min = bcd_next(w_min, L60);
  assign w_nxt_hr  = (w_min == L60) ? bcd_next(w_hr, L24) : w_hr;
  assign w_any_p   = w_p_inc | w_p_aux;
  assign w_match   = w_adv & (w_sec == L60) &
                     (w_nxt_min == w_al_min) &
                     (w_nxt_hr == w_al_hr);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_alarm  <= 1'b0;
      r_al_cnt <= '0;
    end else if (w_match & bus.alarm_en & ~w_any_p) begin
      r_alarm  <= 1'b1;
      r_al_cnt <= '0;
    end else if (r_alarm & (~bus.alarm_en | w_any_p)) begin
      r_alarm <= 1'b0;
    end else if (r_alarm & w_tick_1hz) begin
      if (r_al_cnt == AL_LAST)
        r_alarm <= 1'b0;
      r_al_cnt <= r_al_cnt + 8'd1;
    end
  end

  logic [23:0] w_digits;

  always_comb begin
    w_digits = {w_hr, w_min, w_sec};
    if (w_m_sw)
      w_digits = {w_sw_mm, w_sw_ss, w_sw_cc};
    else if (w_m_am | w_m_ah)
      w_digits = {w_al_hr, w_al_min, 8'h00};
  end

  logic w_unused;
  assign w_unused = &{1'b0, w_div_q, w_hr_co, w_mm_co,
                      w_al_min_co, w_al_hr_co};

  assign bus.digits   = w_digits;
  assign bus.alarm    = r_alarm;
  assign bus.sw_run   = r_sw_run;
  assign bus.tick_1hz = w_tick_1hz;

endmodule

// File: tb/tb_clock_core.sv
// Bench for clock_core: seconds/centiseconds model plus
// directed scenarios with literal expectations.
module tb_clock_core;

  localparam int CLK_HZ    = 200;
  localparam int ALARM_SEC = 8;
  localparam int DIV       = CLK_HZ / 100;
  localparam int SEC_CYC   = DIV * 100;

  logic clk = 1'b0;
  logic rst = 1'b1;

  clock_if bus ();

  clock_core #(
    .CLK_HZ(CLK_HZ),
    .ALARM_SEC(ALARM_SEC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(
    input string nm,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endfunction

  bit m_valid = 1'b0;
  int m_cyc, m_tod, m_alh, m_alm, m_sw, m_rem;
  bit m_run, m_alarm;
  bit [2:0] h_inc, h_aux;

  // Model state: time in seconds of day, stopwatch in
  // centiseconds, buttons as a three-edge sample history.
  always @(posedge clk) begin : model
    bit bi, ba, t100, t1, pi, pa, adv, match, clr;
    int md, nt, h, mi, s;
    bi = bus.btn_inc;
    ba = bus.btn_aux;
    if (rst) begin
      m_valid = 1'b1;
      m_cyc = 0; m_tod = 0; m_alh = 0; m_alm = 0;
      m_sw = 0; m_run = 0; m_alarm = 0; m_rem = 0;
      h_inc = '0; h_aux = '0;
    end else begin
      t100 = (m_cyc % DIV) == DIV - 1;
      t1   = (m_cyc % SEC_CYC) == SEC_CYC - 1;
      m_cyc++;
      pi = h_inc[1] & ~h_inc[2];
      pa = h_aux[1] & ~h_aux[2];
      h_inc = {h_inc[1:0], bi};
      h_aux = {h_aux[1:0], ba};
      md  = (bus.mode == 3'd7) ? 0 : int'(bus.mode);
      adv = t1 && !(md inside {2, 3, 4});
      h  = m_tod / 3600;
      mi = (m_tod / 60) % 60;
      s  = m_tod % 60;
      nt = adv ? (m_tod + 1) % 86400 : m_tod;
      if (pi && md == 2) nt = h*3600 + mi*60 + (s+1)%60;
      if (pi && md == 3) nt = h*3600 + ((mi+1)%60)*60 + s;
      if (pi && md == 4) nt = ((h+1)%24)*3600 + mi*60 + s;
      match = adv && nt == m_alh*3600 + m_alm*60 &&
              bus.alarm_en && !(pi || pa);
      if (match) begin
        m_alarm = 1; m_rem = ALARM_SEC;
      end else if (m_alarm) begin
        if (!bus.alarm_en || pi || pa) m_alarm = 0;
        else if (t1) begin
          m_rem--;
          if (m_rem == 0) m_alarm = 0;
        end
      end
      clr = (md == 1) && pa;
      if (t100 && m_run && !clr) m_sw = (m_sw + 1) % 360000;
      if (clr) begin
        m_sw = 0; m_run = 0;
      end else if (md == 1 && pi) m_run = !m_run;
      if (md == 5 && pi) m_alm = (m_alm + 1) % 60;
      if (md == 6 && pi) m_alh = (m_alh + 1) % 24;
      m_tod = nt;
    end
  end

  function automatic logic [7:0] bcd2(input int v);
    return 8'((v / 10) * 16 + v % 10);
  endfunction

  function automatic logic [23:0] exp_digits();
    int md;
    md = (bus.mode == 3'd7) ? 0 : int'(bus.mode);
    if (md == 1)
      return {bcd2(m_sw / 6000), bcd2((m_sw / 100) % 60),
              bcd2(m_sw % 100)};
    if (md == 5 || md == 6)
      return {bcd2(m_alh), bcd2(m_alm), 8'h00};
    return {bcd2(m_tod / 3600), bcd2((m_tod / 60) % 60),
            bcd2(m_tod % 60)};
  endfunction

  always @(posedge clk) begin
    #2;
    if (m_valid) begin
      chk("digits", bus.digits, exp_digits());
      chk("alarm", bus.alarm, m_alarm);
      chk("sw_run", bus.sw_run, m_run);
      chk("tick_1hz", bus.tick_1hz,
          (m_cyc % SEC_CYC) == SEC_CYC - 1);
    end
  end

  task automatic press(input bit aux, input int hold);
    @(negedge clk);
    if (aux) bus.btn_aux = 1'b1;
    else     bus.btn_inc = 1'b1;
    repeat (hold) @(negedge clk);
    bus.btn_inc = 1'b0;
    bus.btn_aux = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic set_field(input logic [2:0] md, input int n);
    bus.mode = md;
    repeat (n) press(1'b0, 2);
  endtask

  task automatic set_time(input int h, input int mi, input int s);
    bus.mode = 3'd4;
    repeat (2) @(negedge clk);
    repeat ((h - m_tod / 3600 + 24) % 24) press(1'b0, 2);
    bus.mode = 3'd3;
    repeat ((mi - (m_tod / 60) % 60 + 60) % 60) press(1'b0, 2);
    bus.mode = 3'd2;
    repeat ((s - m_tod % 60 + 60) % 60) press(1'b0, 2);
  endtask

  task automatic wait_tick(input string nm);
    int k;
    k = 0;
    while (bus.tick_1hz !== 1'b1 && k < 2 * SEC_CYC) begin
      @(negedge clk);
      k++;
    end
    chk(nm, bus.tick_1hz, 1);
  endtask

  task automatic wait_alarm(input string nm);
    int k;
    k = 0;
    while (bus.alarm !== 1'b1 && k < 2 * SEC_CYC) begin
      @(negedge clk);
      k++;
    end
    chk(nm, bus.alarm, 1);
  endtask

  initial begin
    int n, k;
    bus.mode = 3'd4;
    bus.btn_inc = 1'b0;
    bus.btn_aux = 1'b0;
    bus.alarm_en = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_digits", bus.digits, 24'h000000);
    chk("rst_alarm", bus.alarm, 0);
    chk("rst_sw_run", bus.sw_run, 0);
    chk("rst_tick", bus.tick_1hz, 0);

    set_field(3'd4, 23);
    set_field(3'd3, 59);
    set_field(3'd2, 59);
    chk("set_235959", bus.digits, 24'h235959);

    bus.mode = 3'd4;
    press(1'b0, 50);
    chk("hold_hour_wrap", bus.digits, 24'h005959);
    set_field(3'd4, 23);

    bus.mode = 3'd0;
    wait_tick("wait_tick_wrap");
    chk("pre_wrap", bus.digits, 24'h235959);
    @(negedge clk);
    chk("day_wrap", bus.digits, 24'h000000);

    bus.mode = 3'd1;
    @(negedge clk);
    chk("sw_zero", bus.digits, 24'h000000);
    press(1'b0, 2);
    chk("sw_start", bus.sw_run, 1);
    repeat (61 * SEC_CYC) @(negedge clk);
    press(1'b0, 2);
    chk("sw_stop", bus.sw_run, 0);
    chk("sw_minute", bus.digits[23:16], 8'h01);
    repeat (300) @(negedge clk);
    press(1'b1, 2);
    chk("sw_clr_digits", bus.digits, 24'h000000);
    chk("sw_clr_run", bus.sw_run, 0);

    press(1'b0, 2);
    repeat (40) @(negedge clk);
    @(negedge clk);
    bus.btn_inc = 1'b1;
    bus.btn_aux = 1'b1;
    repeat (2) @(negedge clk);
    bus.btn_inc = 1'b0;
    bus.btn_aux = 1'b0;
    repeat (4) @(negedge clk);
    chk("both_run", bus.sw_run, 0);
    chk("both_digits", bus.digits, 24'h000000);
    press(1'b0, 2);

    set_field(3'd6, 7);
    set_field(3'd5, 30);
    chk("al_disp", bus.digits, 24'h073000);

    bus.alarm_en = 1'b1;
    set_time(7, 29, 59);
    bus.mode = 3'd0;
    wait_alarm("al1_rise");
    chk("al1_digits", bus.digits, 24'h073000);
    n = 0;
    k = 0;
    while (bus.alarm && k < (ALARM_SEC + 2) * SEC_CYC) begin
      if (bus.tick_1hz) n++;
      @(negedge clk);
      k++;
    end
    chk("al1_duration", n, ALARM_SEC);

    set_time(7, 29, 59);
    bus.mode = 3'd0;
    wait_alarm("al2_rise");
    repeat (4) begin
      @(negedge clk);
      wait_tick("al2_sec");
    end
    @(negedge clk);
    bus.btn_aux = 1'b1;
    repeat (2) @(negedge clk);
    chk("al2_aux_n1", bus.alarm, 1);
    @(negedge clk);
    chk("al2_aux_n2", bus.alarm, 0);
    bus.btn_aux = 1'b0;
    repeat (4) @(negedge clk);

    set_time(7, 29, 59);
    bus.mode = 3'd0;
    wait_alarm("al3_rise");
    repeat (2) @(negedge clk);
    bus.alarm_en = 1'b0;
    @(negedge clk);
    chk("al3_en_off", bus.alarm, 0);
    bus.alarm_en = 1'b1;

    set_time(7, 29, 59);
    bus.mode = 3'd0;
    wait_alarm("al4_rise");
    chk("pre_rst_run", bus.sw_run, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_digits", bus.digits, 24'h000000);
    chk("mid_rst_alarm", bus.alarm, 0);
    chk("mid_rst_sw_run", bus.sw_run, 0);
    chk("mid_rst_tick", bus.tick_1hz, 0);
    repeat (20) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_core.md
CLOCK_CORE -- requirements
Module: clock_core

Interface
REQ-001 Parameter CLK_HZ, default 50000000: input clock frequency in Hz; SHALL be a multiple of 100 and at least 200.
REQ-002 Parameter ALARM_SEC, default 60: alarm output duration in seconds, range 1..255.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 mode  in  3  000 CLOCK, 001 STOPWATCH, 010 SET_SEC, 011 SET_MIN, 100 SET_HOUR, 101 SET_AL_MIN, 110 SET_AL_HOUR, 111 treated as CLOCK.
REQ-006 btn_inc  in  1  asynchronous push button: increment, or stopwatch start/stop.
REQ-007 btn_aux  in  1  asynchronous push button: stopwatch clear.
REQ-008 alarm_en  in  1  alarm arm level.
REQ-009 digits  out  24  six BCD nibbles, [23:20] most significant.
REQ-010 alarm  out  1  alarm active.
REQ-011 sw_run  out  1  stopwatch running.
REQ-012 tick_1hz  out  1  one-cycle strobe, once per second.

Function
REQ-013 Prescaler SHALL produce a one-cycle tick_100 every CLK_HZ/100 cycles, and tick_1hz on every 100th tick_100, coincident with it.
REQ-014 All counters SHALL be held directly in BCD; no divide or modulo hardware.
REQ-015 Time-of-day SHALL advance on tick_1hz in all modes except SET_SEC/SET_MIN/SET_HOUR, wrapping 23:59:59 -> 00:00:00 with sec->min->hour carries.
REQ-016 The prescaler SHALL run continuously in every mode; set modes only suppress the time advance.
REQ-017 Each button SHALL pass a 2-FF synchroniser followed by a rising-edge detector; one press yields exactly one pulse regardless of hold length.
REQ-018 A button level first sampled high at edge N SHALL have its effect visible on digits after edge N+2.
REQ-019 In SET_SEC/SET_MIN/SET_HOUR, a btn_inc pulse SHALL increment that field mod 60/60/24, with no carry into other fields.
REQ-020 In SET_AL_MIN/SET_AL_HOUR, a btn_inc pulse SHALL increment the alarm field mod 60/24.
REQ-021 In STOPWATCH mode, a btn_inc pulse SHALL toggle sw_run, and a btn_aux pulse SHALL zero the stopwatch and clear sw_run.
REQ-022 If btn_inc and btn_aux pulse in the same cycle, clear SHALL win.
REQ-023 The stopwatch (MM:SS:CC) SHALL advance on tick_100 while sw_run=1 in any mode, wrapping 59:59.99 -> 00:00.00.
REQ-024 digits SHALL show: HHMMSS of time in CLOCK and the three time-set modes; MMSSCC of the stopwatch in STOPWATCH; alarm HHMM00 in the alarm-set modes.
REQ-025 alarm SHALL set on the tick_1hz edge where time becomes alarm HH:MM:00 while alarm_en=1.
REQ-026 alarm SHALL clear after exactly ALARM_SEC further tick_1hz strobes, or in the cycle after alarm_en=0, or after any button pulse, whichever comes first.
REQ-027 A button pulse coincident with the alarm match SHALL suppress the alarm.
REQ-028 Time advanced past the alarm time via set modes SHALL NOT trigger the alarm.

Reset
REQ-029 While rst=1 at an edge, the following SHALL be zeroed: time, alarm time (00:00), stopwatch, prescaler, synchroniser and edge flops, and the alarm duration counter.
REQ-030 After that edge: digits=24'h000000, alarm=0, sw_run=0, tick_1hz=0.
REQ-031 rst SHALL dominate every concurrent event, including mid-set, a running stopwatch, or an active alarm.

Structure
REQ-032 A shared package clock_pkg SHALL hold the mode encodings, the BCD digit typedef, and the moduli constants (60, 24, 100).
REQ-033 A single sub-module bcd_mod_counter SHALL be used: two-digit BCD, with parameter MOD, inputs inc and clr, and a registered value plus combinational carry-out; it is instantiated for every field.

Verification (CLK_HZ=200)
REQ-034 Set time to 23:59:59 in CLOCK mode, wait one tick_1hz -> digits=000000, with all carries in the same cycle.
REQ-035 SET_HOUR at hour 23, one btn_inc press held 50 cycles -> hour=00, min/sec unchanged, time frozen for the 50 cycles.
REQ-036 STOPWATCH: start, reach 59:59.99, next tick_100 -> 000000 with sw_run=1; then btn_inc -> frozen; then btn_aux -> 000000 and sw_run=0.
REQ-037 Alarm 07:30, alarm_en=1, time 07:29:59 -> alarm=1 on the next tick_1hz for exactly ALARM_SEC seconds; a repeat run with btn_aux at second 5 -> alarm=0 at N+2.
REQ-038 Assert rst for one cycle while the stopwatch runs and alarm=1 -> digits, alarm, sw_run, tick_1hz all 0 on the next cycle.
